rr_mux4_arbiter: RTL and testbench

- Round-robin arbiter that shares one 32-bit output channel between four requesters.
- Drives the select of a mux4_32 instance and registers the selected word into a valid/ready output stage.
- Bounded burst lock: a winner may keep the channel for up to MAX_BURST consecutive beats.
- Sits in front of any shared single-port resource in the MIPS datapath, for example a memory or writeback bus.

---
 rtl/mux4_arb_pkg.sv | 34 +++
 rtl/mux4_32.sv | 24 ++
 rtl/rr_mux4_arbiter.sv | 99 +++++++++
 tb/tb_rr_mux4_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux4_arb_pkg.sv
// Shared types and the rotating priority search used by the round-robin arbiter.
package mux4_arb_pkg;

    localparam int NUM_REQ = 4;

    typedef logic [1:0] sel_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic found;
        sel_t idx;
    } pick_t;

    // First set request bit at or after start, wrapping mod NUM_REQ.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req, input sel_t start);
        pick_t p;
        sel_t  idx;
        p = '0;
        // Walk from the farthest candidate back to start so the nearest one wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = start + sel_t'(k);
            if (req[idx]) begin
                p.found = 1'b1;
                p.idx   = idx;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mux4_32.sv
// Four-to-one word multiplexer for the arbiter data path.
module mux4_32
    import mux4_arb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  sel_t             s,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        unique case (s)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter with bounded burst lock, sharing one registered
// valid/ready output word between four requesters.
module rr_mux4_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [WIDTH-1:0]   d0,
    input  logic [WIDTH-1:0]   d1,
    input  logic [WIDTH-1:0]   d2,
    input  logic [WIDTH-1:0]   d3,
    output logic [NUM_REQ-1:0] gnt,
    output logic [WIDTH-1:0]   y,
    output logic               y_valid,
    input  logic               y_ready,
    output sel_t               s,
    output logic               burst_busy
);

    localparam int CW = $clog2(MAX_BURST + 1);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t CNT_MAX = cnt_t'(MAX_BURST);

    // Handshake: y/y_valid form a valid/ready source; a word leaves when
    // y_valid & y_ready, and a new word may be captured when accept is high.
    arb_state_t       state, state_d;
    sel_t             last;
    cnt_t             burst_cnt, cnt_d;
    logic             valid_d;
    logic             accept, any_req, grant, keep_owner;
    sel_t             start, winner;
    pick_t            pick;
    logic [WIDTH-1:0] mux_y;

    always_comb begin
        accept     = ~y_valid | y_ready;
        any_req    = |req;
        grant      = accept & any_req & ~rst;
        keep_owner = (state == BURST) && req[s] && (burst_cnt < CNT_MAX);
        start      = (state == BURST) ? s + 2'd1 : last + 2'd1;
        pick       = rr_pick(req, start);
        winner     = keep_owner ? s : pick.idx;
        gnt        = grant ? (NUM_REQ'(1) << winner) : '0;
    end

    always_comb begin
        state_d = state;
        cnt_d   = burst_cnt;
        valid_d = y_valid;
        if (accept) begin
            if (any_req) begin
                state_d = BURST;
                valid_d = 1'b1;
                cnt_d   = keep_owner ? burst_cnt + cnt_t'(1) : cnt_t'(1);
            end else begin
                state_d = IDLE;
                valid_d = 1'b0;
                cnt_d   = '0;
            end
        end
    end

    mux4_32 #(.WIDTH(WIDTH)) u_mux (
        .s  (winner),
        .d0 (d0),
        .d1 (d1),
        .d2 (d2),
        .d3 (d3),
        .y  (mux_y)
    );

    // last starts at 3 so requester 0 has first priority after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 2'b11;
            burst_cnt <= '0;
            y         <= '0;
            y_valid   <= 1'b0;
            s         <= 2'b00;
        end else begin
            state     <= state_d;
            burst_cnt <= cnt_d;
            y_valid   <= valid_d;
            if (grant) begin
                y    <= mux_y;
                s    <= winner;
                last <= winner;
            end
        end
    end

    assign burst_busy = (state == BURST);

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Bench for rr_mux4_arbiter: a MAX_BURST=4 and a MAX_BURST=1 instance share
// stimulus and are compared every cycle against a queue-free behavioural model.
module tb_rr_mux4_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] d0, d1, d2, d3;
    logic        y_ready;

    logic [3:0]  gnt_o [2];
    logic [31:0] y_o   [2];
    logic        yv_o  [2];
    logic [1:0]  s_o   [2];
    logic        bb_o  [2];

    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model state per instance: 0 -> MAX_BURST=4, 1 -> MAX_BURST=1.
    int          mb     [2] = '{4, 1};
    int          m_last [2];
    int          m_s    [2];
    int          m_cnt  [2];
    bit          m_busy [2];
    bit          m_yv   [2];
    logic [31:0] m_y    [2];
    logic [3:0]  exp_gnt[2];
    int          w_m    [2];
    bit          acc_m  [2];

    always #5 clk = ~clk;

    rr_mux4_arbiter #(.WIDTH(32), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req(req), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .gnt(gnt_o[0]), .y(y_o[0]), .y_valid(yv_o[0]), .y_ready(y_ready),
        .s(s_o[0]), .burst_busy(bb_o[0])
    );

    rr_mux4_arbiter #(.WIDTH(32), .MAX_BURST(1)) dut_rr (
        .clk(clk), .rst(rst), .req(req), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .gnt(gnt_o[1]), .y(y_o[1]), .y_valid(yv_o[1]), .y_ready(y_ready),
        .s(s_o[1]), .burst_busy(bb_o[1])
    );

    function automatic logic [31:0] data_of(int w);
        case (w)
            0:       return d0;
            1:       return d1;
            2:       return d2;
            default: return d3;
        endcase
    endfunction

    // Winner from the arbitration rules: keep the owner while under budget,
    // otherwise scan the requesters after the owner (or after last) in rotation.
    function automatic int pick_winner(int i);
        int start;
        if (m_busy[i] && req[m_s[i]] && m_cnt[i] < mb[i]) return m_s[i];
        start = m_busy[i] ? m_s[i] : m_last[i];
        for (int k = 1; k <= 4; k++)
            if (req[(start + k) % 4]) return (start + k) % 4;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_last[i] = 3; m_s[i] = 0; m_cnt[i] = 0;
            m_busy[i] = 0; m_yv[i] = 0; m_y[i] = '0;
        end
    endtask

    task automatic predict();
        #1;
        for (int i = 0; i < 2; i++) begin
            acc_m[i]   = !m_yv[i] || y_ready;
            w_m[i]     = pick_winner(i);
            exp_gnt[i] = (acc_m[i] && req != 4'b0) ? 4'(1 << w_m[i]) : 4'b0;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (acc_m[i] && req != 4'b0) begin
                m_cnt[i]  = (m_busy[i] && w_m[i] == m_s[i] && m_cnt[i] < mb[i]) ? m_cnt[i] + 1 : 1;
                m_y[i]    = data_of(w_m[i]);
                m_yv[i]   = 1;
                m_s[i]    = w_m[i];
                m_last[i] = w_m[i];
                m_busy[i] = 1;
            end else if (acc_m[i]) begin
                m_yv[i] = 0; m_busy[i] = 0; m_cnt[i] = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; y_ready = 1'b1;
        d0 = 32'hA0; d1 = 32'hA1; d2 = 32'hA2; d3 = 32'hA3;
        model_reset();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (gnt_o[i] !== 4'b0 || yv_o[i] !== 1'b0 || y_o[i] !== 32'h0 || s_o[i] !== 2'd0 || bb_o[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset inst%0d: gnt=%b v=%b y=%h s=%0d bb=%b want all zero",
                         i, gnt_o[i], yv_o[i], y_o[i], s_o[i], bb_o[i]);
            end
        end
        rst = 1'b0;
        predict();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (gnt_o[i] !== 4'b0001) begin
                n_fail++;
                $display("FAIL reset_first_gnt inst%0d: got %b want 0001", i, gnt_o[i]);
            end
        end
        advance();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (y_o[i] !== 32'hA0 || s_o[i] !== 2'd0 || yv_o[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_first_y inst%0d: got y=%h s=%0d v=%b want y=a0 s=0 v=1",
                         i, y_o[i], s_o[i], yv_o[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        pulse_reset();
        req = 4'b1111; y_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            predict();
            n_checks++;
            if (gnt_o[1] !== exp_gnt[1] || gnt_o[1] !== 4'(1 << (k % 4))) begin
                n_fail++;
                $display("FAIL rr_gnt cyc%0d: got %b want %b", k, gnt_o[1], exp_gnt[1]);
            end
            advance();
            n_checks++;
            if (y_o[1] !== m_y[1] || y_o[1] !== 32'hA0 + 32'(k % 4) || s_o[1] !== 2'(k % 4)) begin
                n_fail++;
                $display("FAIL rr_y cyc%0d: got y=%h s=%0d want y=%h s=%0d", k, y_o[1], s_o[1], m_y[1], m_s[1]);
            end
        end
    endtask

    task automatic test_burst_limit();
        pulse_reset();
        req = 4'b0011; y_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            predict();
            n_checks++;
            if (gnt_o[0] !== exp_gnt[0] || gnt_o[0] !== (((k / 4) % 2 == 1) ? 4'b0010 : 4'b0001)) begin
                n_fail++;
                $display("FAIL burst_gnt cyc%0d: got %b want %b", k, gnt_o[0], exp_gnt[0]);
            end
            advance();
            n_checks++;
            if (bb_o[0] !== 1'b1 || y_o[0] !== m_y[0] || s_o[0] !== 2'(m_s[0])) begin
                n_fail++;
                $display("FAIL burst_out cyc%0d: got bb=%b y=%h s=%0d want bb=1 y=%h s=%0d",
                         k, bb_o[0], y_o[0], s_o[0], m_y[0], m_s[0]);
            end
        end
    endtask

    task automatic test_lone_requester();
        pulse_reset();
        req = 4'b0100; y_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            predict();
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (gnt_o[i] !== 4'b0100) begin
                    n_fail++;
                    $display("FAIL lone_gnt inst%0d cyc%0d: got %b want 0100", i, k, gnt_o[i]);
                end
            end
            advance();
            n_checks++;
            if (int'(dut.burst_cnt) !== (k % 4) + 1 || m_cnt[0] !== (k % 4) + 1 || yv_o[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL lone_cnt cyc%0d: got cnt=%0d v=%b want cnt=%0d v=1",
                         k, dut.burst_cnt, yv_o[0], (k % 4) + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] y_hold;
        logic [1:0]  s_hold;
        req = 4'b1000; y_ready = 1'b1; d3 = 32'h0000_D3D3;
        predict();
        advance();
        y_hold = y_o[0]; s_hold = s_o[0];
        d3 = 32'h1234_5678; y_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            predict();
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (gnt_o[i] !== 4'b0 || gnt_o[i] !== exp_gnt[i]) begin
                    n_fail++;
                    $display("FAIL stall_gnt inst%0d cyc%0d: got %b want 0000", i, k, gnt_o[i]);
                end
            end
            advance();
            n_checks++;
            if (y_o[0] !== y_hold || s_o[0] !== s_hold || yv_o[0] !== 1'b1 || y_o[0] !== 32'h0000_D3D3) begin
                n_fail++;
                $display("FAIL stall_hold cyc%0d: got y=%h s=%0d v=%b want y=%h s=%0d v=1",
                         k, y_o[0], s_o[0], yv_o[0], y_hold, s_hold);
            end
        end
        y_ready = 1'b1;
        predict();
        n_checks++;
        if (gnt_o[0] !== 4'b1000) begin
            n_fail++;
            $display("FAIL release_gnt: got %b want 1000", gnt_o[0]);
        end
        advance();
        n_checks++;
        if (y_o[0] !== 32'h1234_5678 || s_o[0] !== 2'd3) begin
            n_fail++;
            $display("FAIL release_y: got y=%h s=%0d want y=12345678 s=3", y_o[0], s_o[0]);
        end
    endtask

    task automatic test_drain();
        req = 4'b0000; y_ready = 1'b1;
        predict();
        advance();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (yv_o[i] !== 1'b0 || bb_o[i] !== 1'b0 || y_o[i] !== m_y[i] || y_o[i] !== 32'h1234_5678) begin
                n_fail++;
                $display("FAIL drain inst%0d: got v=%b bb=%b y=%h want v=0 bb=0 y=12345678",
                         i, yv_o[i], bb_o[i], y_o[i]);
            end
        end
    endtask

    task automatic test_mid_burst_reset();
        req = 4'b0110; y_ready = 1'b1;
        repeat (2) begin
            predict();
            advance();
        end
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (gnt_o[i] !== 4'b0 || yv_o[i] !== 1'b0 || y_o[i] !== 32'h0 || s_o[i] !== 2'd0 || bb_o[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst inst%0d: gnt=%b v=%b y=%h s=%0d bb=%b want all zero",
                         i, gnt_o[i], yv_o[i], y_o[i], s_o[i], bb_o[i]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        req = 4'b1111;
        predict();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (gnt_o[i] !== 4'b0001) begin
                n_fail++;
                $display("FAIL midrst_restart inst%0d: got %b want 0001", i, gnt_o[i]);
            end
        end
        advance();
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            req     = 4'($urandom_range(0, 15));
            y_ready = ($urandom_range(0, 3) != 0);
            d0 = $urandom; d1 = $urandom; d2 = $urandom; d3 = $urandom;
            predict();
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (gnt_o[i] !== exp_gnt[i]) begin
                    n_fail++;
                    $display("FAIL rand_gnt inst%0d cyc%0d: got %b want %b", i, k, gnt_o[i], exp_gnt[i]);
                end
            end
            advance();
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (y_o[i] !== m_y[i] || yv_o[i] !== m_yv[i] || s_o[i] !== 2'(m_s[i]) || bb_o[i] !== m_busy[i]) begin
                    n_fail++;
                    $display("FAIL rand_out inst%0d cyc%0d: got y=%h v=%b s=%0d bb=%b want y=%h v=%b s=%0d bb=%b",
                             i, k, y_o[i], yv_o[i], s_o[i], bb_o[i], m_y[i], m_yv[i], m_s[i], m_busy[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_burst_limit();
        test_lone_requester();
        test_backpressure();
        test_drain();
        test_mid_burst_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
